// File: rtl/inst_fetch_queue.sv
// Instruction fetch queue: generates sequential fetch PCs, drives a 1-cycle
// latency instruction SRAM, buffers returned words with their PCs and hands
// them to decode over a valid/allowin handshake. A branch flush redirects the
// PC and discards everything buffered or in flight.
module inst_fetch_queue #(
    parameter logic [31:0] RESET_PC = 32'h1c000000,
    parameter int unsigned DEPTH    = 4,
    parameter int unsigned CNT_W    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    output logic             inst_sram_en_o,
    output logic [31:0]      inst_sram_addr_o,
    input  logic [31:0]      inst_sram_rdata_i,
    input  logic             br_flush_i,
    input  logic [31:0]      br_target_i,
    input  logic             id_allowin_i,
    output logic             id_valid_o,
    output logic [31:0]      id_inst_o,
    output logic [31:0]      id_pc_o,
    output logic [CNT_W-1:0] fq_count_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    logic [31:0]      pc_r;
    logic [31:0]      inflight_pc_r;
    logic             inflight_r;
    logic [PTR_W-1:0] rptr_r;
    logic [PTR_W-1:0] wptr_r;
    logic [CNT_W-1:0] count_r;

    logic [31:0]      mem_inst [DEPTH];
    logic [31:0]      mem_pc   [DEPTH];

    logic [CNT_W:0]   used;
    logic             has_credit;
    logic             req;
    logic             enq;
    logic             deq;
    logic             head_valid;

    // Low target bits are architecturally ignored; the redirect PC is word aligned.
    logic             unused_target_bits;
    assign unused_target_bits = ^br_target_i[1:0];

    // Credit check, request, enqueue and dequeue qualification.
    always_comb begin
        used       = {1'b0, count_r} + (CNT_W + 1)'(inflight_r);
        has_credit = used < (CNT_W + 1)'(DEPTH);
        req        = rst_n & ~br_flush_i & has_credit;
        enq        = inflight_r & ~br_flush_i;
        head_valid = (count_r != '0) & ~br_flush_i;
        deq        = head_valid & id_allowin_i;
    end

    // Output drive: SRAM request and head-of-queue presentation.
    always_comb begin
        inst_sram_en_o   = req;
        inst_sram_addr_o = {pc_r[31:2], 2'b00};
        id_valid_o       = head_valid;
        id_inst_o        = '0;
        id_pc_o          = '0;
        if (count_r != '0) begin
            id_inst_o = mem_inst[rptr_r];
            id_pc_o   = mem_pc[rptr_r];
        end
        fq_count_o       = count_r;
    end

    // Fetch PC, in-flight tracking, pointers and occupancy; flush wins over all.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_r          <= RESET_PC;
            inflight_r    <= 1'b0;
            inflight_pc_r <= '0;
            rptr_r        <= '0;
            wptr_r        <= '0;
            count_r       <= '0;
        end else if (br_flush_i) begin
            pc_r       <= {br_target_i[31:2], 2'b00};
            inflight_r <= 1'b0;
            rptr_r     <= '0;
            wptr_r     <= '0;
            count_r    <= '0;
        end else begin
            inflight_r <= req;
            if (req) begin
                pc_r          <= pc_r + 32'd4;
                inflight_pc_r <= pc_r;
            end
            if (enq) begin
                wptr_r <= wptr_r + 1'b1;
            end
            if (deq) begin
                rptr_r <= rptr_r + 1'b1;
            end
            case ({enq, deq})
                2'b10:   count_r <= count_r + 1'b1;
                2'b01:   count_r <= count_r - 1'b1;
                default: count_r <= count_r;
            endcase
        end
    end

    // Queue storage; contents are only observed when count is non-zero.
    always_ff @(posedge clk) begin
        if (enq) begin
            mem_inst[wptr_r] <= inst_sram_rdata_i;
            mem_pc[wptr_r]   <= inflight_pc_r;
        end
    end

    // The credit rule must make an enqueue into a full queue impossible.
    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(enq && !deq && count_r == CNT_W'(DEPTH)));

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Directed, table-driven bench for inst_fetch_queue with a 1-cycle SRAM model.
module tb_inst_fetch_queue;

    localparam logic [31:0] P  = 32'h1c000000;
    localparam logic [31:0] Q  = 32'hFFFFFFF8;
    localparam logic [31:0] K  = 32'hA5A5A5A5;

    typedef struct {
        logic        rst_n;
        logic        flush;
        logic [31:0] target;
        logic        allow;
        logic        en;
        logic [31:0] addr;
        logic        valid;
        logic [31:0] pc;
        logic [2:0]  cnt;
    } vec_t;

    vec_t vecs[$];

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic [31:0] target;
    logic        allow;
    logic        en;
    logic [31:0] addr;
    logic [31:0] rdata;
    logic        valid;
    logic [31:0] inst;
    logic [31:0] pc;
    logic [2:0]  cnt;

    logic        rst2_n;
    logic        en2;
    logic [31:0] addr2;
    logic [31:0] rdata2;
    logic        valid2;
    logic [31:0] inst2;
    logic [31:0] pc2;
    logic [2:0]  cnt2;

    int applied;
    int miscompares;

    inst_fetch_queue #(.RESET_PC(P), .DEPTH(4)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .inst_sram_en_o    (en),
        .inst_sram_addr_o  (addr),
        .inst_sram_rdata_i (rdata),
        .br_flush_i        (flush),
        .br_target_i       (target),
        .id_allowin_i      (allow),
        .id_valid_o        (valid),
        .id_inst_o         (inst),
        .id_pc_o           (pc),
        .fq_count_o        (cnt)
    );

    inst_fetch_queue #(.RESET_PC(Q), .DEPTH(4)) dut_wrap (
        .clk               (clk),
        .rst_n             (rst2_n),
        .inst_sram_en_o    (en2),
        .inst_sram_addr_o  (addr2),
        .inst_sram_rdata_i (rdata2),
        .br_flush_i        (1'b0),
        .br_target_i       (32'h0),
        .id_allowin_i      (1'b1),
        .id_valid_o        (valid2),
        .id_inst_o         (inst2),
        .id_pc_o           (pc2),
        .fq_count_o        (cnt2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous SRAM models: data = addr ^ K one cycle after the request.
    always @(posedge clk) begin
        if (en)  rdata  <= addr ^ K;
        if (en2) rdata2 <= addr2 ^ K;
    end

    function automatic void add(logic r, logic f, logic [31:0] t, logic a,
                                logic e, logic [31:0] ad, logic v,
                                logic [31:0] p, logic [2:0] c);
        vec_t x;
        x.rst_n = r; x.flush = f; x.target = t; x.allow = a;
        x.en = e; x.addr = ad; x.valid = v; x.pc = p; x.cnt = c;
        vecs.push_back(x);
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        applied++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    initial begin
        applied     = 0;
        miscompares = 0;
        rst_n  = 1'b0;
        rst2_n = 1'b0;
        flush  = 1'b0;
        target = '0;
        allow  = 1'b1;
        rdata  = '0;
        rdata2 = '0;

        // rst flush target allow | en addr valid pc cnt
        // Streaming from reset, then back-pressure and a flush at count=3 with a response in flight.
        add(0,0,0,1,        0, P,         0, 0,         0);
        add(1,0,0,1,        1, P,         0, 0,         0);
        add(1,0,0,1,        1, P+'h4,     0, 0,         0);
        add(1,0,0,1,        1, P+'h8,     1, P,         1);
        add(1,0,0,1,        1, P+'hc,     1, P+'h4,     1);
        add(1,0,0,1,        1, P+'h10,    1, P+'h8,     1);
        add(1,0,0,0,        1, P+'h14,    1, P+'hc,     1);
        add(1,0,0,0,        1, P+'h18,    1, P+'hc,     2);
        add(1,1,P+'h103,0,  0, P+'h1c,    0, P+'hc,     3);
        add(1,0,0,0,        1, P+'h100,   0, 0,         0);
        add(1,0,0,0,        1, P+'h104,   0, 0,         0);
        add(1,0,0,0,        1, P+'h108,   1, P+'h100,   1);
        // Count held at 2 with simultaneous enqueue and dequeue.
        add(1,0,0,1,        1, P+'h10c,   1, P+'h100,   2);
        add(1,0,0,1,        1, P+'h110,   1, P+'h104,   2);
        add(1,0,0,1,        1, P+'h114,   1, P+'h108,   2);
        // Fill to DEPTH with allowin low from reset, then drain and resume.
        add(0,0,0,0,        0, P,         0, 0,         0);
        add(1,0,0,0,        1, P,         0, 0,         0);
        add(1,0,0,0,        1, P+'h4,     0, 0,         0);
        add(1,0,0,0,        1, P+'h8,     1, P,         1);
        add(1,0,0,0,        1, P+'hc,     1, P,         2);
        add(1,0,0,0,        0, P+'h10,    1, P,         3);
        add(1,0,0,0,        0, P+'h10,    1, P,         4);
        add(1,0,0,0,        0, P+'h10,    1, P,         4);
        add(1,0,0,1,        0, P+'h10,    1, P,         4);
        add(1,0,0,1,        1, P+'h10,    1, P+'h4,     3);
        add(1,0,0,1,        1, P+'h14,    1, P+'h8,     2);
        add(1,0,0,1,        1, P+'h18,    1, P+'hc,     2);
        add(1,0,0,1,        1, P+'h1c,    1, P+'h10,    2);
        add(1,0,0,0,        1, P+'h20,    1, P+'h14,    2);
        add(1,0,0,0,        0, P+'h24,    1, P+'h14,    3);

        for (int i = 0; i < vecs.size(); i++) begin
            logic [31:0] exp_inst;
            @(negedge clk);
            rst_n  = vecs[i].rst_n;
            flush  = vecs[i].flush;
            target = vecs[i].target;
            allow  = vecs[i].allow;
            #1;
            exp_inst = (vecs[i].cnt != 0) ? (vecs[i].pc ^ K) : 32'h0;
            check($sformatf("vec%0d", i),
                  {27'h0, en, addr, valid, pc, inst, cnt},
                  {27'h0, vecs[i].en, vecs[i].addr, vecs[i].valid, vecs[i].pc, exp_inst, vecs[i].cnt});
        end

        // Asynchronous reset mid-stream (count=3), no clock edge in between.
        #1 rst_n = 1'b0;
        #1;
        check("async_reset", {124'h0, en, valid, (cnt != 0), (pc != 0)}, 128'h0);
        @(negedge clk);
        rst_n = 1'b1;
        allow = 1'b1;
        #1;
        check("restart_addr", {59'h0, en, addr, valid, cnt, 32'h0}, {59'h0, 1'b1, P, 1'b0, 3'd0, 32'h0});
        @(negedge clk);
        @(negedge clk);
        #1;
        check("restart_head", {63'h0, valid, pc, inst}, {63'h0, 1'b1, P, P ^ K});

        // PC wraps modulo 2^32 from a high reset address.
        @(negedge clk);
        rst2_n = 1'b1;
        #1;
        check("wrap_addr0", {95'h0, en2, addr2}, {95'h0, 1'b1, Q});
        @(negedge clk); #1;
        check("wrap_addr1", {95'h0, en2, addr2}, {95'h0, 1'b1, 32'hFFFFFFFC});
        @(negedge clk); #1;
        check("wrap_addr2", {63'h0, addr2, valid2, pc2}, {63'h0, 32'h0, 1'b1, Q});
        @(negedge clk); #1;
        check("wrap_pc1", {64'h0, pc2, inst2}, {64'h0, 32'hFFFFFFFC, 32'hFFFFFFFC ^ K});
        @(negedge clk); #1;
        check("wrap_pc2", {64'h0, pc2, inst2}, {64'h0, 32'h0, K});
        @(negedge clk); #1;
        check("wrap_pc3", {63'h0, addr2, valid2, pc2}, {63'h0, 32'hC, 1'b1, 32'h4});

        $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
        $finish;
    end

endmodule
